// File: rtl/clk_rst_sequencer.sv
// Power-up / recovery reset sequencer for the EPD clock domain.
// It pulses the DCM reset and waits for a qualified LOCKED. It then releases
// the MIG system reset, waits for DDR calibration, and finally releases the
// EPD-domain reset. Losing lock or calibration restarts the whole sequence.
// Optional feature: define CLK_RST_RETRY_LIMIT_EN to stop in FAULT after
// MAX_RETRY failed attempts. Only rstn leaves FAULT.
module clk_rst_sequencer #(
  parameter int unsigned DCM_RST_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned CALIB_TIMEOUT  = 2**22,
  parameter int unsigned MAX_RETRY      = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       dcm_locked,
  input  logic       ddr_calib_done,
  output logic       dcm_reset,
  output logic       ddr_rst,
  output logic       epd_rstn,
  output logic       sys_ready,
  output logic [2:0] seq_state,
  output logic [3:0] retry_cnt
);

  typedef enum logic [2:0] {
    ST_DCM_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_WAIT_CAL  = 3'd3,
    ST_RUN       = 3'd4
`ifdef CLK_RST_RETRY_LIMIT_EN
    , ST_FAULT   = 3'd5
`endif
  } state_t;

  // One shared phase counter. It is sized for the longest interval and is
  // cleared on every state entry. It never wraps, because each counting
  // state leaves at its terminal count.
  localparam int unsigned MAX_AB = (DCM_RST_CYCLES > LOCK_TIMEOUT) ? DCM_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CD = (LOCK_STABLE > CALIB_TIMEOUT) ? LOCK_STABLE : CALIB_TIMEOUT;
  localparam int unsigned MAX_TC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W  = (MAX_TC > 1) ? $clog2(MAX_TC) : 1;

  localparam logic [CNT_W-1:0] DCM_LAST    = CNT_W'(DCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] CAL_LAST    = CNT_W'(CALIB_TIMEOUT - 1);

`ifdef CLK_RST_RETRY_LIMIT_EN
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);
`else
  // MAX_RETRY only has an effect with the retry limit enabled. Both builds
  // keep the same parameter list.
  localparam int unsigned unused_max_retry = MAX_RETRY;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d, retry_inc;
  logic             fail;
  logic [1:0]       lock_sync, cal_sync;
  logic             lock_s, cal_s;
  logic             dcm_reset_d, ddr_rst_d, epd_rstn_d, sys_ready_d;

  // Two-flop synchronisers for the asynchronous DCM and MIG status inputs.
  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples the pre-edge value, so the two stages form a real two-cycle delay.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lock_sync <= '0;
      cal_sync  <= '0;
    end else begin
      lock_sync <= {lock_sync[0], dcm_locked};
      cal_sync  <= {cal_sync[0], ddr_calib_done};
    end
  end

  assign lock_s = lock_sync[1];
  assign cal_s  = cal_sync[1];

  // Next-state, counter and retry bookkeeping. A lock loss is checked first,
  // so it wins over calibration-done and over a timeout on the same edge.
  // NOTE: every signal gets a default before the case. Otherwise a path that
  // does not assign a signal would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    fail    = 1'b0;
    unique case (state_q)
      ST_DCM_RST: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == DCM_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (lock_s)                 state_d = ST_STABLE;
        else if (cnt_q == LOCK_LAST) fail   = 1'b1;
      end
      ST_STABLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!lock_s)                   fail    = 1'b1;
        else if (cnt_q == STABLE_LAST) state_d = ST_WAIT_CAL;
      end
      ST_WAIT_CAL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!lock_s)                fail    = 1'b1;
        else if (cal_s)             state_d = ST_RUN;
        else if (cnt_q == CAL_LAST) fail    = 1'b1;
      end
      ST_RUN: begin
        if (!lock_s || !cal_s) fail = 1'b1;
      end
`ifdef CLK_RST_RETRY_LIMIT_EN
      ST_FAULT: state_d = ST_FAULT;
`endif
      default: state_d = ST_DCM_RST;
    endcase

    retry_inc = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
    if (fail) begin
      retry_d = retry_inc;
`ifdef CLK_RST_RETRY_LIMIT_EN
      state_d = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_DCM_RST;
`else
      state_d = ST_DCM_RST;
`endif
    end

    if (state_d == ST_RUN && state_q != ST_RUN) retry_d = '0;
    if (state_d != state_q) cnt_d = '0;
  end

  // Decode the outputs from the next state. The registered outputs then
  // change on the same edge as the state.
  always_comb begin
    dcm_reset_d = 1'b1;
    ddr_rst_d   = 1'b1;
    epd_rstn_d  = 1'b0;
    sys_ready_d = 1'b0;
    case (state_d)
      ST_WAIT_LOCK, ST_STABLE: dcm_reset_d = 1'b0;
      ST_WAIT_CAL: begin
        dcm_reset_d = 1'b0;
        ddr_rst_d   = 1'b0;
      end
      ST_RUN: begin
        dcm_reset_d = 1'b0;
        ddr_rst_d   = 1'b0;
        epd_rstn_d  = 1'b1;
        sys_ready_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counter, retry count and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_DCM_RST;
      cnt_q     <= '0;
      retry_q   <= '0;
      dcm_reset <= 1'b1;
      ddr_rst   <= 1'b1;
      epd_rstn  <= 1'b0;
      sys_ready <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      dcm_reset <= dcm_reset_d;
      ddr_rst   <= ddr_rst_d;
      epd_rstn  <= epd_rstn_d;
      sys_ready <= sys_ready_d;
    end
  end

  assign seq_state = state_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Self-checking bench for clk_rst_sequencer.
// The timeouts are scaled down so that repeated retries stay short.
// A phase/elapsed-time model predicts every output on every cycle. Directed
// scenarios add hand-computed latency and count checks.
// Build with CLK_RST_RETRY_LIMIT_EN defined to exercise the FAULT path.
module tb_clk_rst_sequencer;

  localparam int DCM = 8;
  localparam int LT  = 64;
  localparam int LS  = 32;
  localparam int CT  = 1024;
  localparam int MR  = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       dcm_locked = 1'b0;
  logic       ddr_calib_done = 1'b0;
  logic       dcm_reset, ddr_rst, epd_rstn, sys_ready;
  logic [2:0] seq_state;
  logic [3:0] retry_cnt;

  always #5 clk = ~clk;

  clk_rst_sequencer #(
    .DCM_RST_CYCLES(DCM),
    .LOCK_TIMEOUT  (LT),
    .LOCK_STABLE   (LS),
    .CALIB_TIMEOUT (CT),
    .MAX_RETRY     (MR)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .dcm_locked    (dcm_locked),
    .ddr_calib_done(ddr_calib_done),
    .dcm_reset     (dcm_reset),
    .ddr_rst       (ddr_rst),
    .epd_rstn      (epd_rstn),
    .sys_ready     (sys_ready),
    .seq_state     (seq_state),
    .retry_cnt     (retry_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model. The phase number is the published encoding, and
  // elapsed counts cycles since the phase began. The synchroniser is modelled
  // as a two-sample delay of the raw inputs.
  int         m_phase   = 0;
  int         m_elapsed = 0;
  int         m_retry   = 0;
  bit         m_valid   = 1'b0;
  logic [1:0] lock_pipe = '0;
  logic [1:0] cal_pipe  = '0;

  function automatic void m_go(input int p);
    m_phase   = p;
    m_elapsed = 0;
    if (p == 4) m_retry = 0;
  endfunction

  function automatic void m_fail();
    m_retry = (m_retry < 15) ? m_retry + 1 : 15;
`ifdef CLK_RST_RETRY_LIMIT_EN
    m_go((m_retry == MR) ? 5 : 0);
`else
    m_go(0);
`endif
  endfunction

  function automatic void m_step(input logic lk, input logic cl);
    case (m_phase)
      0: if (m_elapsed == DCM - 1) m_go(1); else m_elapsed++;
      1: if (lk) m_go(2); else if (m_elapsed == LT - 1) m_fail(); else m_elapsed++;
      2: if (!lk) m_fail(); else if (m_elapsed == LS - 1) m_go(3); else m_elapsed++;
      3: if (!lk) m_fail(); else if (cl) m_go(4); else if (m_elapsed == CT - 1) m_fail(); else m_elapsed++;
      4: if (!lk || !cl) m_fail();
      default: ;
    endcase
  endfunction

  // Per-cycle compare of every output against the model.
  always @(posedge clk) begin
    logic lk, cl;
    logic [10:0] exp_v;
    cyc++;
    lk = lock_pipe[1];
    cl = cal_pipe[1];
    if (!rstn) begin
      m_valid   = 1'b1;
      m_phase   = 0;
      m_elapsed = 0;
      m_retry   = 0;
      lock_pipe = '0;
      cal_pipe  = '0;
    end else begin
      lock_pipe = {lock_pipe[0], dcm_locked};
      cal_pipe  = {cal_pipe[0], ddr_calib_done};
      m_step(lk, cl);
    end
    #1;
    if (m_valid) begin
      exp_v = {3'(m_phase),
               1'(m_phase == 0 || m_phase == 5),
               1'(m_phase != 3 && m_phase != 4),
               1'(m_phase == 4),
               1'(m_phase == 4),
               4'(m_retry)};
      check($sformatf("outputs@%0d", cyc),
            {seq_state, dcm_reset, ddr_rst, epd_rstn, sys_ready, retry_cnt}, exp_v);
    end
  end

  function automatic logic get_out(input int sel);
    case (sel)
      0: return dcm_reset;
      1: return ddr_rst;
      2: return epd_rstn;
      default: return sys_ready;
    endcase
  endfunction

  // Wait on negedges until an output reaches a value. An expired budget
  // counts as a failed comparison.
  task automatic wait_out(input int sel, input logic val, input int budget,
                          input string name, output int waited);
    waited = 0;
    while (get_out(sel) !== val && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (get_out(sel) !== val) begin
      n_total++;
      $display("FAIL %s: timeout after %0d cycles", name, budget);
    end
  endtask

  int r_cyc;

  task automatic apply_reset(input int n);
    @(negedge clk);
    rstn = 1'b0;
    repeat (n) @(negedge clk);
    rstn  = 1'b1;
    r_cyc = cyc;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, c0, c1;
    bit saw_ready;

    // Reset values.
    apply_reset(3);
    check("rst_state", seq_state, 0);
    check("rst_dcm_reset", dcm_reset, 1);
    check("rst_ddr_rst", ddr_rst, 1);
    check("rst_epd_rstn", epd_rstn, 0);
    check("rst_sys_ready", sys_ready, 0);
    check("rst_retry", retry_cnt, 0);

    // Minimum latency: lock appears as dcm_reset falls, and cal appears as
    // ddr_rst falls.
    wait_out(0, 1'b0, 40, "min_dcm_fall", w);
    check("dcm_pulse_len", cyc - r_cyc, DCM);
    dcm_locked = 1'b1;
    wait_out(1, 1'b0, 100, "min_ddr_fall", w);
    check("ddr_release_time", cyc - r_cyc, DCM + 3 + LS);
    ddr_calib_done = 1'b1;
    wait_out(3, 1'b1, 100, "min_ready", w);
    check("min_latency", cyc - r_cyc, DCM + 2 + LS + 2 + 2);
    check("min_retry", retry_cnt, 0);

    // T1: lock 20 cycles after dcm_reset falls, cal 500 cycles later.
    dcm_locked = 1'b0;
    ddr_calib_done = 1'b0;
    apply_reset(2);
    wait_out(0, 1'b0, 40, "t1_dcm_fall", w);
    repeat (20) @(negedge clk);
    dcm_locked = 1'b1;
    repeat (500) @(negedge clk);
    ddr_calib_done = 1'b1;
    wait_out(3, 1'b1, 100, "t1_ready", w);
    check("t1_latency", cyc - r_cyc, 531);
    check("t1_state", seq_state, 4);
    check("t1_retry", retry_cnt, 0);

    // T4: lock loss in RUN, then recovery.
    @(negedge clk);
    dcm_locked = 1'b0;
    wait_out(0, 1'b1, 3, "t4_dcm_rise", w);
    check("t4_loss_latency", w, 3);
    check("t4_epd_rstn", epd_rstn, 0);
    check("t4_ddr_rst", ddr_rst, 1);
    check("t4_retry", retry_cnt, 1);
    wait_out(0, 1'b0, 20, "t4_dcm_fall", w);
    dcm_locked = 1'b1;
    wait_out(3, 1'b1, 100, "t4_recover", w);
    check("t4_retry_cleared", retry_cnt, 0);

    // Calibration loss in RUN.
    @(negedge clk);
    ddr_calib_done = 1'b0;
    wait_out(0, 1'b1, 3, "cal_loss_dcm_rise", w);
    check("cal_loss_latency", w, 3);
    check("cal_loss_retry", retry_cnt, 1);
    wait_out(1, 1'b0, 100, "cal_loss_ddr_fall", w);
    ddr_calib_done = 1'b1;
    wait_out(3, 1'b1, 100, "cal_loss_recover", w);

    // T3: one-cycle lock glitch during STABLE.
    dcm_locked = 1'b0;
    ddr_calib_done = 1'b0;
    apply_reset(2);
    wait_out(0, 1'b0, 40, "t3_dcm_fall", w);
    dcm_locked = 1'b1;
    repeat (20) @(negedge clk);
    dcm_locked = 1'b0;
    @(negedge clk);
    dcm_locked = 1'b1;
    wait_out(0, 1'b1, 5, "t3_dcm_rise", w);
    check("t3_state", seq_state, 0);
    check("t3_retry", retry_cnt, 1);
    wait_out(1, 1'b0, 100, "t3_ddr_fall", w);
    ddr_calib_done = 1'b1;
    wait_out(3, 1'b1, 100, "t3_ready", w);
    check("t3_retry_cleared", retry_cnt, 0);

    // T5: lock_s falls on the same edge that cal_s rises in WAIT_CAL.
    dcm_locked = 1'b0;
    ddr_calib_done = 1'b0;
    apply_reset(2);
    wait_out(0, 1'b0, 40, "t5_dcm_fall", w);
    dcm_locked = 1'b1;
    wait_out(1, 1'b0, 100, "t5_ddr_fall", w);
    repeat (5) @(negedge clk);
    dcm_locked = 1'b0;
    ddr_calib_done = 1'b1;
    saw_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw_ready |= sys_ready;
      if (i == 2) begin
        check("t5_state", seq_state, 0);
        check("t5_retry", retry_cnt, 1);
      end
    end
    check("t5_no_ready", saw_ready, 0);

    // Calibration timeout at the terminal count.
    dcm_locked = 1'b0;
    ddr_calib_done = 1'b0;
    apply_reset(2);
    wait_out(0, 1'b0, 40, "ct_dcm_fall", w);
    dcm_locked = 1'b1;
    wait_out(1, 1'b0, 100, "ct_ddr_fall", w);
    c0 = cyc;
    wait_out(1, 1'b1, CT + 10, "ct_ddr_rise", w);
    check("ct_timeout_len", cyc - c0, CT);
    check("ct_dcm_reset", dcm_reset, 1);
    check("ct_retry", retry_cnt, 1);

    // T2: lock never arrives.
    dcm_locked = 1'b0;
    ddr_calib_done = 1'b0;
    apply_reset(2);
    wait_out(0, 1'b0, 40, "t2_dcm_fall", w);
    c0 = cyc;
    wait_out(0, 1'b1, LT + 10, "t2_first_timeout", w);
    check("t2_lock_timeout_len", cyc - c0, LT);
    check("t2_retry1", retry_cnt, 1);
    c1 = cyc;
    for (int k = 2; k <= 3; k++) begin
      wait_out(0, 1'b0, 20, "t2_dcm_fall_k", w);
      wait_out(0, 1'b1, LT + 10, "t2_timeout_k", w);
      check($sformatf("t2_period%0d", k), cyc - c1, DCM + LT);
      check($sformatf("t2_retry%0d", k), retry_cnt, k);
      c1 = cyc;
    end
`ifdef CLK_RST_RETRY_LIMIT_EN
    // T6: the fourth timeout enters FAULT. Only rstn leaves it.
    wait_out(0, 1'b0, 20, "t6_dcm_fall", w);
    repeat (LT) @(negedge clk);
    check("t6_fault_state", seq_state, 5);
    check("t6_fault_retry", retry_cnt, MR);
    check("t6_fault_dcm_reset", dcm_reset, 1);
    dcm_locked = 1'b1;
    ddr_calib_done = 1'b1;
    repeat (200) @(negedge clk);
    check("t6_fault_hold", seq_state, 5);
    check("t6_fault_no_ready", sys_ready, 0);
    apply_reset(1);
    check("t6_rst_state", seq_state, 0);
    check("t6_rst_retry", retry_cnt, 0);
`else
    // Retries continue indefinitely, and the count saturates at 15.
    repeat (14 * (DCM + LT)) @(negedge clk);
    check("t2_retry_sat", retry_cnt, 15);
    check("t2_still_retrying", seq_state inside {3'd0, 3'd1}, 1);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
